// File: rtl/llc_set_engine_pkg.sv
// Shared LLC types: MESI, bus-op and snoop encodings, trace op codes, default geometry.
// Purely declarative; no timing or backpressure of its own.
package llc_set_engine_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    typedef enum logic [2:0] {
        BUS_NONE  = 3'd0,
        BUS_READ  = 3'd1,
        BUS_WRITE = 3'd2,
        BUS_RWIM  = 3'd3,
        BUS_INVAL = 3'd4
    } bus_op_e;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'd0,
        SNP_HIT   = 2'd1,
        SNP_HITM  = 2'd2
    } snoop_e;

    localparam logic [3:0] OP_READ      = 4'd0;
    localparam logic [3:0] OP_WRITE     = 4'd1;
    localparam logic [3:0] OP_IFETCH    = 4'd2;
    localparam logic [3:0] OP_SNP_INVAL = 4'd3;
    localparam logic [3:0] OP_SNP_READ  = 4'd4;
    localparam logic [3:0] OP_SNP_WRITE = 4'd5;
    localparam logic [3:0] OP_SNP_RWIM  = 4'd6;
    localparam logic [3:0] OP_CLEAR     = 4'd8;

    localparam int DEF_ADDR_BITS = 32;
    localparam int DEF_WAYS      = 8;
    localparam int DEF_LINE_SIZE = 64;
    localparam int DEF_SETS      = 16384;

    function automatic logic is_cpu_op(input logic [3:0] op);
        return (op <= OP_IFETCH);
    endfunction

    function automatic logic is_snoop_op(input logic [3:0] op);
        return (op >= OP_SNP_INVAL) && (op <= OP_SNP_RWIM);
    endfunction

endpackage

// File: rtl/llc_set_engine_plru_tree.sv
// Tree pseudo-LRU for one set: victim way from the node bits, and next bits after touching a way.
// Purely combinational, no backpressure. Bit clear = LRU side is the lower half.
module llc_set_engine_plru_tree #(
    parameter  int WAYS     = 8,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]     plru_bits,
    input  logic [WAY_BITS-1:0] touch_way,
    output logic [WAY_BITS-1:0] victim_way,
    output logic [WAYS-2:0]     next_bits
);

    // Heap layout: node n (1..WAYS-1) lives at tree_cur[n], children 2n and 2n+1.
    logic [2*WAYS-1:0] tree_cur;
    logic [WAY_BITS:0] node;
    logic [WAY_BITS:0] leaf;

    assign tree_cur = {{WAYS{1'b0}}, plru_bits, 1'b0};
    assign leaf     = {1'b1, touch_way};

    always_comb begin
        node = (WAY_BITS+1)'(1);
        for (int l = 0; l < WAY_BITS; l++) begin
            node = {node[WAY_BITS-1:0], tree_cur[node]};
        end
        victim_way = node[WAY_BITS-1:0];
    end

    // A node is on the touched path when it is an ancestor of the touched leaf.
    for (genvar n = 1; n < WAYS; n++) begin : g_node
        localparam int D = $clog2(n + 1) - 1;
        logic on_path;
        logic dir;
        assign on_path          = ((leaf >> (WAY_BITS - D)) == (WAY_BITS+1)'(n));
        assign dir              = leaf[WAY_BITS-D-1];
        assign next_bits[n-1]   = on_path ? ~dir : plru_bits[n-1];
    end

endmodule

// File: rtl/llc_set_engine.sv
// Set-associative LLC tag/MESI/PLRU engine; accept-to-rsp_valid 3 cycles, one command per 4 cycles.
// req_ready is high only in IDLE; a held request is taken once the engine returns there.
module llc_set_engine
    import llc_set_engine_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int WAYS      = DEF_WAYS,
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int SETS      = DEF_SETS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [3:0]                  req_op,
    input  logic [ADDR_BITS-1:0]        req_addr,
    input  logic                        req_other_hit,
    output logic                        rsp_valid,
    output logic                        rsp_hit,
    output logic [$clog2(WAYS)-1:0]     rsp_way,
    output logic [2:0]                  rsp_bus_op,
    output logic                        rsp_evict_dirty,
    output logic [1:0]                  rsp_snoop,
    output logic [31:0]                 hit_count,
    output logic [31:0]                 miss_count
);

    localparam int IDX_BITS  = $clog2(SETS);
    localparam int OFF_BITS  = $clog2(LINE_SIZE);
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int TAG_BITS  = ADDR_BITS - IDX_BITS - OFF_BITS;
    localparam int LINE_BITS = ADDR_BITS - OFF_BITS;

    typedef enum logic [2:0] {
        ST_CLEAR, ST_IDLE, ST_LOOKUP, ST_UPDATE, ST_RESP
    } state_e;

    logic [WAYS*TAG_BITS-1:0] tag_mem  [SETS];
    logic [WAYS*2-1:0]        mesi_mem [SETS];
    logic [WAYS-2:0]          plru_mem [SETS];

    logic [WAYS*TAG_BITS-1:0] rd_tag_q;
    logic [WAYS*2-1:0]        rd_mesi_q;
    logic [WAYS-2:0]          rd_plru_q;

    state_e                state_q, state_d;
    logic [IDX_BITS-1:0]   clr_idx_q, clr_idx_d;
    logic [3:0]            op_q, op_d;
    logic [LINE_BITS-1:0]  line_q, line_d;
    logic                  oth_q, oth_d;
    logic                  lk_hit_q, lk_hit_d;
    logic [WAY_BITS-1:0]   lk_way_q, lk_way_d;
    mesi_e                 lk_mesi_q, lk_mesi_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic [WAY_BITS-1:0]   rsp_way_q, rsp_way_d;
    bus_op_e               rsp_bus_op_q, rsp_bus_op_d;
    logic                  rsp_evict_q, rsp_evict_d;
    snoop_e                rsp_snoop_q, rsp_snoop_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;

    logic                  accept;
    logic [IDX_BITS-1:0]   req_idx;
    logic [IDX_BITS-1:0]   cur_idx;
    logic [TAG_BITS-1:0]   cur_tag;
    logic                  unused_offset;

    assign accept        = req_valid && (state_q == ST_IDLE);
    assign req_idx       = req_addr[OFF_BITS +: IDX_BITS];
    assign cur_idx       = line_q[IDX_BITS-1:0];
    assign cur_tag       = line_q[LINE_BITS-1 -: TAG_BITS];
    assign unused_offset = ^req_addr[OFF_BITS-1:0];

    // Lookup: tag compare across ways, then pick hit way / lowest invalid / PLRU victim.
    logic                hit_any;
    logic [WAY_BITS-1:0] hit_way;
    logic                any_inv;
    logic [WAY_BITS-1:0] inv_way;
    logic [WAY_BITS-1:0] sel_way;
    mesi_e               sel_mesi;
    logic [WAY_BITS-1:0] plru_victim;
    logic [WAYS-2:0]     plru_next;

    llc_set_engine_plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_bits  (rd_plru_q),
        .touch_way  (lk_way_q),
        .victim_way (plru_victim),
        .next_bits  (plru_next)
    );

    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        any_inv  = 1'b0;
        inv_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mesi_e'(rd_mesi_q[w*2 +: 2]) == MESI_I) begin
                any_inv = 1'b1;
                inv_way = WAY_BITS'(w);
            end else if (rd_tag_q[w*TAG_BITS +: TAG_BITS] == cur_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
        sel_way  = hit_any ? hit_way : (any_inv ? inv_way : plru_victim);
        sel_mesi = MESI_I;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_BITS'(w) == sel_way) sel_mesi = mesi_e'(rd_mesi_q[w*2 +: 2]);
        end
    end

    // Update: new MESI for the selected way plus bus/snoop classification.
    mesi_e                    new_st;
    bus_op_e                  upd_bus;
    snoop_e                   upd_snp;
    logic                     upd_evict;
    logic                     upd_fill;
    logic [WAYS*2-1:0]        upd_mesi;
    logic [WAYS*TAG_BITS-1:0] upd_tag;
    logic [WAYS-2:0]          upd_plru;

    always_comb begin
        new_st    = lk_mesi_q;
        upd_bus   = BUS_NONE;
        upd_snp   = SNP_NOHIT;
        upd_evict = 1'b0;
        upd_fill  = 1'b0;
        if (is_cpu_op(op_q)) begin
            if (lk_hit_q) begin
                if (op_q == OP_WRITE) begin
                    new_st  = MESI_M;
                    upd_bus = (lk_mesi_q == MESI_S) ? BUS_INVAL : BUS_NONE;
                end
            end else begin
                upd_fill  = 1'b1;
                upd_evict = (lk_mesi_q == MESI_M);
                if (op_q == OP_WRITE) begin
                    new_st  = MESI_M;
                    upd_bus = BUS_RWIM;
                end else begin
                    new_st  = oth_q ? MESI_S : MESI_E;
                    upd_bus = BUS_READ;
                end
            end
        end else if (lk_hit_q) begin
            upd_snp = (lk_mesi_q == MESI_M) ? SNP_HITM : SNP_HIT;
            case (op_q)
                OP_SNP_READ: new_st = MESI_S;
                OP_SNP_RWIM: new_st = MESI_I;
                OP_SNP_INVAL: begin
                    // M/E here is a protocol violation: leave the line alone, still report HIT.
                    upd_snp = SNP_HIT;
                    if (lk_mesi_q == MESI_S) new_st = MESI_I;
                end
                default: ;
            endcase
        end

        upd_mesi = rd_mesi_q;
        upd_tag  = rd_tag_q;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_BITS'(w) == lk_way_q) begin
                upd_mesi[w*2 +: 2] = new_st;
                if (upd_fill) upd_tag[w*TAG_BITS +: TAG_BITS] = cur_tag;
            end
        end
        upd_plru = is_cpu_op(op_q) ? plru_next : rd_plru_q;
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mesi_mem[clr_idx_q] <= '0;
            plru_mem[clr_idx_q] <= '0;
        end else if (state_q == ST_UPDATE) begin
            mesi_mem[cur_idx] <= upd_mesi;
            plru_mem[cur_idx] <= upd_plru;
            tag_mem[cur_idx]  <= upd_tag;
        end
        if (accept) begin
            rd_tag_q  <= tag_mem[req_idx];
            rd_mesi_q <= mesi_mem[req_idx];
            rd_plru_q <= plru_mem[req_idx];
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        op_d         = op_q;
        line_d       = line_q;
        oth_d        = oth_q;
        lk_hit_d     = lk_hit_q;
        lk_way_d     = lk_way_q;
        lk_mesi_d    = lk_mesi_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_way_d    = rsp_way_q;
        rsp_bus_op_d = rsp_bus_op_q;
        rsp_evict_d  = rsp_evict_q;
        rsp_snoop_d  = rsp_snoop_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_BITS'(SETS - 1)) begin
                    state_d    = ST_IDLE;
                    clr_idx_d  = '0;
                    hit_cnt_d  = '0;
                    miss_cnt_d = '0;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    op_d         = req_op;
                    line_d       = req_addr[ADDR_BITS-1:OFF_BITS];
                    oth_d        = req_other_hit;
                    rsp_hit_d    = 1'b0;
                    rsp_way_d    = '0;
                    rsp_bus_op_d = BUS_NONE;
                    rsp_evict_d  = 1'b0;
                    rsp_snoop_d  = SNP_NOHIT;
                    if (is_cpu_op(req_op) || is_snoop_op(req_op)) begin
                        state_d = ST_LOOKUP;
                    end else if (req_op == OP_CLEAR) begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = '0;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_LOOKUP: begin
                lk_hit_d  = hit_any;
                lk_way_d  = sel_way;
                lk_mesi_d = sel_mesi;
                state_d   = ST_UPDATE;
            end
            ST_UPDATE: begin
                rsp_hit_d    = lk_hit_q;
                // A snoop miss has no meaningful way; report 0 rather than the victim.
                rsp_way_d    = (is_snoop_op(op_q) && !lk_hit_q) ? '0 : lk_way_q;
                rsp_bus_op_d = upd_bus;
                rsp_evict_d  = upd_evict;
                rsp_snoop_d  = upd_snp;
                if (is_cpu_op(op_q)) begin
                    if (lk_hit_q) begin
                        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
                    end else begin
                        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
                    end
                end
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_idx_q    <= '0;
            op_q         <= '0;
            line_q       <= '0;
            oth_q        <= 1'b0;
            lk_hit_q     <= 1'b0;
            lk_way_q     <= '0;
            lk_mesi_q    <= MESI_I;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_bus_op_q <= BUS_NONE;
            rsp_evict_q  <= 1'b0;
            rsp_snoop_q  <= SNP_NOHIT;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            op_q         <= op_d;
            line_q       <= line_d;
            oth_q        <= oth_d;
            lk_hit_q     <= lk_hit_d;
            lk_way_q     <= lk_way_d;
            lk_mesi_q    <= lk_mesi_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_way_q    <= rsp_way_d;
            rsp_bus_op_q <= rsp_bus_op_d;
            rsp_evict_q  <= rsp_evict_d;
            rsp_snoop_q  <= rsp_snoop_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign rsp_valid       = (state_q == ST_RESP);
    assign rsp_hit         = rsp_hit_q;
    assign rsp_way         = rsp_way_q;
    assign rsp_bus_op      = rsp_bus_op_q;
    assign rsp_evict_dirty = rsp_evict_q;
    assign rsp_snoop       = rsp_snoop_q;
    assign hit_count       = hit_cnt_q;
    assign miss_count      = miss_cnt_q;

endmodule

// File: tb/tb_llc_set_engine.sv
// Directed plus random command stream for llc_set_engine (4 ways, 16 sets) checked against a line-level cache model.
module tb_llc_set_engine;

    localparam int AB = 32;
    localparam int NW = 4;
    localparam int NS = 16;
    localparam int LS = 64;

    localparam int SI = 0, SS = 1, SE = 2, SM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic        req_other_hit = 1'b0;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [1:0]  rsp_way;
    logic [2:0]  rsp_bus_op;
    logic        rsp_evict_dirty;
    logic [1:0]  rsp_snoop;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    llc_set_engine #(.ADDR_BITS(AB), .WAYS(NW), .LINE_SIZE(LS), .SETS(NS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_other_hit   (req_other_hit),
        .rsp_valid       (rsp_valid),
        .rsp_hit         (rsp_hit),
        .rsp_way         (rsp_way),
        .rsp_bus_op      (rsp_bus_op),
        .rsp_evict_dirty (rsp_evict_dirty),
        .rsp_snoop       (rsp_snoop),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    int total = 0;
    int bad   = 0;

    int          m_st  [NS][NW];
    int unsigned m_tag [NS][NW];
    bit          m_pl  [NS][NW];
    int unsigned m_hits, m_miss;
    int e_hit, e_way, e_bus, e_ev, e_snp;
    int g_hit, g_way, g_bus, g_ev, g_snp;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_st[s][w] = SI;
                m_pl[s][w] = 1'b0;
            end
        m_hits = 0;
        m_miss = 0;
    endfunction

    // Binary tree over the ways; a node bit of 1 means the upper half is least recently used.
    function automatic int plru_victim(input int s);
        int node = 1, lo = 0, size = NW;
        while (size > 1) begin
            int half = size / 2;
            if (m_pl[s][node]) begin lo += half; node = 2 * node + 1; end
            else node = 2 * node;
            size = half;
        end
        return lo;
    endfunction

    function automatic void plru_touch(input int s, input int way);
        int node = 1, lo = 0, size = NW;
        while (size > 1) begin
            int half = size / 2;
            if (way < lo + half) begin m_pl[s][node] = 1'b1; node = 2 * node; end
            else begin m_pl[s][node] = 1'b0; lo += half; node = 2 * node + 1; end
            size = half;
        end
    endfunction

    function automatic void model_cmd(input int op, input logic [31:0] a, input bit oth);
        int s  = int'((a >> 6) % NS);
        int unsigned t = a >> 10;
        int hw = -1;
        int cls;
        e_hit = 0; e_way = 0; e_bus = 0; e_ev = 0; e_snp = 0;
        for (int w = 0; w < NW; w++)
            if (m_st[s][w] != SI && m_tag[s][w] == t) hw = w;
        if (op <= 2) begin
            if (hw >= 0) begin
                e_hit = 1; e_way = hw;
                if (op == 1) begin
                    e_bus = (m_st[s][hw] == SS) ? 4 : 0;
                    m_st[s][hw] = SM;
                end
                if (m_hits != 32'hFFFF_FFFF) m_hits++;
            end else begin
                e_way = -1;
                for (int w = NW - 1; w >= 0; w--) if (m_st[s][w] == SI) e_way = w;
                if (e_way < 0) e_way = plru_victim(s);
                e_ev  = (m_st[s][e_way] == SM);
                e_bus = (op == 1) ? 3 : 1;
                m_st[s][e_way]  = (op == 1) ? SM : (oth ? SS : SE);
                m_tag[s][e_way] = t;
                if (m_miss != 32'hFFFF_FFFF) m_miss++;
            end
            plru_touch(s, e_way);
        end else if (op <= 6) begin
            if (hw >= 0) begin
                e_hit = 1; e_way = hw;
                cls = (m_st[s][hw] == SM) ? 2 : 1;
                case (op)
                    3: begin e_snp = 1; if (m_st[s][hw] == SS) m_st[s][hw] = SI; end
                    4: begin e_snp = cls; m_st[s][hw] = SS; end
                    5: e_snp = cls;
                    default: begin e_snp = cls; m_st[s][hw] = SI; end
                endcase
            end
        end else if (op == 8) begin
            model_clear();
        end
    endfunction

    task automatic count_clear(input string name);
        int  n = 0;
        bit  saw = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
            if (req_ready) break;
            n++;
        end
        check({name, "_ready_low_cycles"}, n, 16);
        check({name, "_no_rsp"}, saw, 0);
        check({name, "_hit_count"}, hit_count, m_hits);
        check({name, "_miss_count"}, miss_count, m_miss);
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [31:0] a, input bit oth);
        int n = 0;
        bit seen = 0;
        model_cmd(int'(op), a, oth);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        check("ready_wait", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_other_hit = oth;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (op == 4'd8) begin
            count_clear("op8");
            return;
        end
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin n = i; seen = 1; break; end
        end
        check("rsp_seen", seen, 1);
        check("latency", n, (op <= 4'd6) ? 3 : 1);
        g_hit = int'(rsp_hit); g_way = int'(rsp_way); g_bus = int'(rsp_bus_op);
        g_ev = int'(rsp_evict_dirty); g_snp = int'(rsp_snoop);
        check("rsp_hit", rsp_hit, e_hit);
        check("rsp_way", rsp_way, e_way);
        check("rsp_bus_op", rsp_bus_op, e_bus);
        check("rsp_evict_dirty", rsp_evict_dirty, e_ev);
        check("rsp_snoop", rsp_snoop, e_snp);
        @(negedge clk);
        check("rsp_pulse_one_cycle", rsp_valid, 0);
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_miss);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [3:0] op;
        logic [31:0] a;

        model_clear();
        #23;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fields", {rsp_hit, rsp_way, rsp_bus_op, rsp_evict_dirty, rsp_snoop}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_clear("reset");

        do_cmd(4'd0, 32'h0000_0000, 1'b0);
        check("rd0_first_hit", g_hit, 0);
        check("rd0_first_way", g_way, 0);
        check("rd0_first_bus", g_bus, 1);
        do_cmd(4'd0, 32'h0000_0000, 1'b0);
        check("rd0_second_hit", g_hit, 1);
        check("rd0_second_bus", g_bus, 0);
        check("rd0_hits", hit_count, 1);
        check("rd0_misses", miss_count, 1);

        do_cmd(4'd1, 32'h0000_0040, 1'b0);
        check("wr40_bus", g_bus, 3);
        do_cmd(4'd4, 32'h0000_0040, 1'b0);
        check("snprd40_snoop", g_snp, 2);
        do_cmd(4'd1, 32'h0000_0040, 1'b0);
        check("wr40_again_hit", g_hit, 1);
        check("wr40_again_bus", g_bus, 4);

        for (int k = 0; k < 5; k++) do_cmd(4'd1, k * 32'h400, 1'b0);
        check("fifth_way", g_way, 0);
        check("fifth_evict", g_ev, 1);
        check("fifth_bus", g_bus, 3);

        do_cmd(4'd0, 32'h0000_0080, 1'b0);
        do_cmd(4'd6, 32'h0000_0080, 1'b0);
        check("rwim_e_snoop", g_snp, 1);
        do_cmd(4'd0, 32'h0000_0080, 1'b0);
        check("rwim_then_read_hit", g_hit, 0);

        do_cmd(4'd0, 32'h0000_00C0, 1'b1);
        do_cmd(4'd5, 32'h0000_00C0, 1'b0);
        do_cmd(4'd3, 32'h0000_00C0, 1'b0);
        do_cmd(4'd4, 32'h0000_00C0, 1'b0);
        check("inval_s_then_snoop", g_snp, 0);
        do_cmd(4'd7, 32'h0000_0000, 1'b0);
        do_cmd(4'd12, 32'h0000_0040, 1'b1);

        do_cmd(4'd8, 32'h0, 1'b0);
        do_cmd(4'd0, 32'h0000_0000, 1'b0);
        check("after_clear_rd0_hit", g_hit, 0);
        do_cmd(4'd0, 32'h0000_0040, 1'b0);
        check("after_clear_rd40_hit", g_hit, 0);

        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 19));
            if (r <= 5 || r == 19) op = 4'd0;
            else if (r <= 9)       op = 4'd1;
            else if (r <= 11)      op = 4'd2;
            else if (r == 12)      op = 4'd3;
            else if (r <= 14)      op = 4'd4;
            else if (r == 15)      op = 4'd5;
            else if (r <= 17)      op = 4'd6;
            else                   op = ($urandom_range(0, 1) == 0) ? 4'd7 : 4'($urandom_range(9, 15));
            a = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 1) << 6) | $urandom_range(0, 63);
            do_cmd(op, a, 1'($urandom_range(0, 1)));
        end

        do_cmd(4'd1, 32'h0000_1000, 1'b0);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0; req_addr = 32'h0000_1000; req_other_hit = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst_ready", req_ready, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_hit_count", hit_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        count_clear("midrst");
        do_cmd(4'd0, 32'h0000_1000, 1'b0);
        check("midrst_line_gone", g_hit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
